bus_datapath: RTL and testbench

BUS_DATAPATH -- requirements
Module: bus_datapath

---
 rtl/bus_datapath_pkg.sv | 20 ++
 rtl/bus_datapath_if.sv | 38 +++
 rtl/bus_datapath_alu_core.sv | 33 +++
 rtl/bus_datapath.sv | 92 +++++++++
 tb/tb_bus_datapath.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/bus_datapath_pkg.sv
// Shared definitions for the bus datapath and its controller: bus widths
// and the ALU select codes, kept in one place so both sides agree.
package bus_datapath_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 8;
  localparam int OPCODE_W = 4;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_NOTA  = 3'b101,
    ALU_PASSB = 3'b110,
    ALU_PASSA = 3'b111
  } alu_sel_e;

endpackage

// File: rtl/bus_datapath_if.sv
// Controller <-> datapath signal bundle. The controller (master) drives the
// strobes, bus enables, ALU select and program-memory data; the datapath
// (slave) returns the opcode, both buses, the accumulator and the flags.
interface bus_datapath_if;
  import bus_datapath_pkg::*;

  logic                c0;
  logic                c1;
  logic                c2;
  logic                c3;
  logic                c4;
  logic                en1;
  logic                en2;
  logic                en3;
  logic                en4;
  logic                en5;
  logic                en6;
  logic [2:0]          s1;
  logic [DATA_W-1:0]   pm_rdata;
  logic [OPCODE_W-1:0] opcode;
  logic [ADDR_W-1:0]   addr_bus;
  logic [DATA_W-1:0]   data_bus;
  logic [DATA_W-1:0]   acc;
  logic                zf;
  logic                cf;
  logic                bus_conflict;

  modport master (
    output c0, c1, c2, c3, c4, en1, en2, en3, en4, en5, en6, s1, pm_rdata,
    input  opcode, addr_bus, data_bus, acc, zf, cf, bus_conflict
  );

  modport slave (
    input  c0, c1, c2, c3, c4, en1, en2, en3, en4, en5, en6, s1, pm_rdata,
    output opcode, addr_bus, data_bus, acc, zf, cf, bus_conflict
  );

endinterface

// File: rtl/bus_datapath_alu_core.sv
// Combinational 8-bit ALU. Carry-out is only meaningful for add (carry)
// and subtract (borrow, i.e. a < b); every other operation reports 0.
module alu_core
  import bus_datapath_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        sel,
  output logic [DATA_W-1:0] y,
  output logic              cout
);

  // Select the operation; result and carry default to zero first
  always_comb begin
    y    = '0;
    cout = 1'b0;
    case (sel)
      ALU_ADD:   {cout, y} = {1'b0, a} + {1'b0, b};
      ALU_SUB:   begin
                   y    = a - b;
                   cout = (a < b);
                 end
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_XOR:   y = a ^ b;
      ALU_NOTA:  y = ~a;
      ALU_PASSB: y = b;
      ALU_PASSA: y = a;
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/bus_datapath.sv
// Accumulator datapath around a shared address bus and data bus. Both buses
// are priority muxes, so a register loading from a bus it also drives just
// reloads its own value; all feedback goes through registers.
module bus_datapath
  import bus_datapath_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  bus_datapath_if.slave bus
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] acc_q;
  logic              zf_q;
  logic              cf_q;
  logic              conflict_q;

  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] data_mux;
  logic [DATA_W-1:0] alu_y;
  logic              alu_cout;
  logic [2:0]        data_drivers;
  logic              conflict_next;

  alu_core u_alu (
    .a    (acc_q),
    .b    (mdr),
    .sel  (bus.s1),
    .y    (alu_y),
    .cout (alu_cout)
  );

  // Address bus: PC wins over MAR, idle bus reads zero
  always_comb begin
    addr_mux = '0;
    if (bus.en1)      addr_mux = pc;
    else if (bus.en2) addr_mux = mar;
  end

  // Data bus: memory > ALU > IR > MDR, idle bus reads zero
  always_comb begin
    data_mux = '0;
    if (bus.en3)      data_mux = bus.pm_rdata;
    else if (bus.en4) data_mux = alu_y;
    else if (bus.en5) data_mux = ir;
    else if (bus.en6) data_mux = mdr;
  end

  // Flag any bus that has more than one enabled driver this cycle
  always_comb begin
    data_drivers  = {2'b00, bus.en3} + {2'b00, bus.en4}
                  + {2'b00, bus.en5} + {2'b00, bus.en6};
    conflict_next = (bus.en1 & bus.en2) | (data_drivers >= 3'd2);
  end

  // Register file, accumulator/flags and the registered conflict flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= '0;
      mar        <= '0;
      ir         <= '0;
      mdr        <= '0;
      acc_q      <= '0;
      zf_q       <= 1'b0;
      cf_q       <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      if (bus.c1) pc  <= pc + 8'd1;
      if (bus.c2) mar <= data_mux;
      if (bus.c3) ir  <= data_mux;
      if (bus.c4) mdr <= data_mux;
      if (bus.c0) begin
        acc_q <= alu_y;
        zf_q  <= (alu_y == '0);
        cf_q  <= alu_cout;
      end
      conflict_q <= conflict_next;
    end
  end

  assign bus.opcode       = ir[DATA_W-1 -: OPCODE_W];
  assign bus.addr_bus     = addr_mux;
  assign bus.data_bus     = data_mux;
  assign bus.acc          = acc_q;
  assign bus.zf           = zf_q;
  assign bus.cf           = cf_q;
  assign bus.bus_conflict = conflict_q;

endmodule

// File: tb/tb_bus_datapath.sv
// Directed self-checking bench for bus_datapath. Inputs change 1 time unit
// after a rising edge and outputs are sampled there too.
module tb_bus_datapath;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [7:0] alu_exp [0:7];

  bus_datapath_if dp_if ();

  bus_datapath dut (
    .clk (clk),
    .rst (rst),
    .bus (dp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    dp_if.c0 = 0; dp_if.c1 = 0; dp_if.c2 = 0; dp_if.c3 = 0; dp_if.c4 = 0;
    dp_if.en1 = 0; dp_if.en2 = 0; dp_if.en3 = 0; dp_if.en4 = 0;
    dp_if.en5 = 0; dp_if.en6 = 0; dp_if.s1 = 3'b000; dp_if.pm_rdata = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    tick();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic load_mdr(input logic [7:0] v);
    clear_inputs();
    dp_if.pm_rdata = v; dp_if.en3 = 1; dp_if.c4 = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    dp_if.en1 = 1;
    tick();
    tick();
    checks++; if (dp_if.addr_bus !== 8'h00) begin errors++; $display("[TB] FAIL reset_pc: got %h want 00", dp_if.addr_bus); end
    checks++; if (dp_if.acc !== 8'h00) begin errors++; $display("[TB] FAIL reset_acc: got %h want 00", dp_if.acc); end
    checks++; if (dp_if.opcode !== 4'h0) begin errors++; $display("[TB] FAIL reset_opcode: got %h want 0", dp_if.opcode); end
    checks++; if ({dp_if.zf, dp_if.cf, dp_if.bus_conflict} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b want 000", {dp_if.zf, dp_if.cf, dp_if.bus_conflict}); end
    dp_if.en1 = 0;
    #1;
    checks++; if (dp_if.data_bus !== 8'h00 || dp_if.addr_bus !== 8'h00) begin errors++; $display("[TB] FAIL idle_buses: got %h/%h want 00/00", dp_if.addr_bus, dp_if.data_bus); end
    #2;
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    do_reset();
    dp_if.c1 = 1;
    repeat (3) tick();
    clear_inputs();
    dp_if.pm_rdata = 8'hA5; dp_if.en1 = 1; dp_if.en3 = 1; dp_if.c3 = 1;
    #1;
    checks++; if (dp_if.addr_bus !== 8'h03) begin errors++; $display("[TB] FAIL fetch_addr: got %h want 03", dp_if.addr_bus); end
    checks++; if (dp_if.data_bus !== 8'hA5) begin errors++; $display("[TB] FAIL fetch_data: got %h want a5", dp_if.data_bus); end
    checks++; if (dp_if.opcode !== 4'h0) begin errors++; $display("[TB] FAIL fetch_opcode_early: got %h want 0", dp_if.opcode); end
    tick();
    clear_inputs();
    checks++; if (dp_if.opcode !== 4'hA) begin errors++; $display("[TB] FAIL fetch_opcode: got %h want a", dp_if.opcode); end
    checks++; if (dp_if.bus_conflict !== 1'b0) begin errors++; $display("[TB] FAIL fetch_conflict: got %b want 0", dp_if.bus_conflict); end
  endtask

  task automatic test_wrap();
    do_reset();
    dp_if.c1 = 1;
    repeat (255) tick();
    dp_if.en1 = 1;
    #1;
    checks++; if (dp_if.addr_bus !== 8'hFF) begin errors++; $display("[TB] FAIL wrap_pre: got %h want ff", dp_if.addr_bus); end
    tick();
    checks++; if (dp_if.addr_bus !== 8'h00) begin errors++; $display("[TB] FAIL wrap_post: got %h want 00", dp_if.addr_bus); end
    clear_inputs();
  endtask

  task automatic test_alu();
    do_reset();
    load_mdr(8'hF0);
    dp_if.s1 = 3'b110; dp_if.c0 = 1;
    tick();
    clear_inputs();
    checks++; if (dp_if.acc !== 8'hF0) begin errors++; $display("[TB] FAIL alu_passb_load: got %h want f0", dp_if.acc); end
    load_mdr(8'h20);
    dp_if.s1 = 3'b000; dp_if.c0 = 1;
    tick();
    clear_inputs();
    checks++; if ({dp_if.acc, dp_if.cf, dp_if.zf} !== {8'h10, 1'b1, 1'b0}) begin errors++; $display("[TB] FAIL alu_add: got acc=%h cf=%b zf=%b want acc=10 cf=1 zf=0", dp_if.acc, dp_if.cf, dp_if.zf); end
    load_mdr(8'h10);
    dp_if.s1 = 3'b001; dp_if.c0 = 1;
    tick();
    clear_inputs();
    checks++; if ({dp_if.acc, dp_if.cf, dp_if.zf} !== {8'h00, 1'b0, 1'b1}) begin errors++; $display("[TB] FAIL alu_sub: got acc=%h cf=%b zf=%b want acc=00 cf=0 zf=1", dp_if.acc, dp_if.cf, dp_if.zf); end
    load_mdr(8'h20);
    dp_if.s1 = 3'b001; dp_if.c0 = 1;
    tick();
    clear_inputs();
    checks++; if ({dp_if.acc, dp_if.cf, dp_if.zf} !== {8'hE0, 1'b1, 1'b0}) begin errors++; $display("[TB] FAIL alu_borrow: got acc=%h cf=%b zf=%b want acc=e0 cf=1 zf=0", dp_if.acc, dp_if.cf, dp_if.zf); end
  endtask

  task automatic test_alu_ops();
    do_reset();
    load_mdr(8'hF0);
    dp_if.s1 = 3'b110; dp_if.c0 = 1;
    tick();
    load_mdr(8'h3C);
    alu_exp = '{8'h2C, 8'hB4, 8'h30, 8'hFC, 8'hCC, 8'h0F, 8'h3C, 8'hF0};
    for (int i = 0; i < 8; i++) begin
      dp_if.s1 = 3'(i); dp_if.en4 = 1;
      #1;
      checks++; if (dp_if.data_bus !== alu_exp[i]) begin errors++; $display("[TB] FAIL alu_op%0d: got %h want %h", i, dp_if.data_bus, alu_exp[i]); end
    end
    clear_inputs();
    dp_if.s1 = 3'b000; dp_if.c0 = 1;
    tick();
    checks++; if ({dp_if.acc, dp_if.cf} !== {8'h2C, 1'b1}) begin errors++; $display("[TB] FAIL alu_add_wrap: got acc=%h cf=%b want acc=2c cf=1", dp_if.acc, dp_if.cf); end
    dp_if.s1 = 3'b010;
    tick();
    clear_inputs();
    checks++; if ({dp_if.acc, dp_if.cf, dp_if.zf} !== {8'h2C, 1'b0, 1'b0}) begin errors++; $display("[TB] FAIL alu_and_carry: got acc=%h cf=%b zf=%b want acc=2c cf=0 zf=0", dp_if.acc, dp_if.cf, dp_if.zf); end
  endtask

  task automatic test_conflict();
    do_reset();
    load_mdr(8'h22);
    dp_if.pm_rdata = 8'h11; dp_if.en3 = 1; dp_if.en6 = 1;
    #1;
    checks++; if (dp_if.data_bus !== 8'h11) begin errors++; $display("[TB] FAIL conflict_data: got %h want 11", dp_if.data_bus); end
    checks++; if (dp_if.bus_conflict !== 1'b0) begin errors++; $display("[TB] FAIL conflict_early: got %b want 0", dp_if.bus_conflict); end
    tick();
    clear_inputs();
    dp_if.en6 = 1;
    checks++; if (dp_if.bus_conflict !== 1'b1) begin errors++; $display("[TB] FAIL conflict_set: got %b want 1", dp_if.bus_conflict); end
    tick();
    checks++; if (dp_if.bus_conflict !== 1'b0) begin errors++; $display("[TB] FAIL conflict_clear: got %b want 0", dp_if.bus_conflict); end
    checks++; if (dp_if.data_bus !== 8'h22) begin errors++; $display("[TB] FAIL conflict_mdr: got %h want 22", dp_if.data_bus); end
    clear_inputs();
    dp_if.c1 = 1;
    tick();
    clear_inputs();
    dp_if.en1 = 1; dp_if.en2 = 1;
    #1;
    checks++; if (dp_if.addr_bus !== 8'h01) begin errors++; $display("[TB] FAIL addr_priority: got %h want 01", dp_if.addr_bus); end
    tick();
    clear_inputs();
    checks++; if (dp_if.bus_conflict !== 1'b1) begin errors++; $display("[TB] FAIL addr_conflict: got %b want 1", dp_if.bus_conflict); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    dp_if.pm_rdata = 8'h6B; dp_if.en3 = 1; dp_if.c2 = 1; dp_if.c3 = 1; dp_if.c4 = 1;
    tick();
    clear_inputs();
    dp_if.en2 = 1; dp_if.en6 = 1;
    #1;
    checks++; if ({dp_if.addr_bus, dp_if.data_bus, dp_if.opcode} !== {8'h6B, 8'h6B, 4'h6}) begin errors++; $display("[TB] FAIL multi_load: got mar=%h mdr=%h op=%h want 6b 6b 6", dp_if.addr_bus, dp_if.data_bus, dp_if.opcode); end
    dp_if.c4 = 1;
    tick();
    dp_if.c4 = 0;
    #1;
    checks++; if (dp_if.data_bus !== 8'h6B) begin errors++; $display("[TB] FAIL self_load: got %h want 6b", dp_if.data_bus); end
    clear_inputs();
    dp_if.en5 = 1;
    #1;
    checks++; if (dp_if.data_bus !== 8'h6B) begin errors++; $display("[TB] FAIL ir_drive: got %h want 6b", dp_if.data_bus); end
    clear_inputs();
    repeat (3) tick();
    dp_if.en1 = 1; dp_if.en6 = 1;
    #1;
    checks++; if ({dp_if.addr_bus, dp_if.data_bus, dp_if.acc} !== {8'h00, 8'h6B, 8'h00}) begin errors++; $display("[TB] FAIL hold: got pc=%h mdr=%h acc=%h want 00 6b 00", dp_if.addr_bus, dp_if.data_bus, dp_if.acc); end
    clear_inputs();
  endtask

  task automatic test_mid_reset();
    do_reset();
    dp_if.pm_rdata = 8'hC3; dp_if.en3 = 1; dp_if.c3 = 1; dp_if.c4 = 1;
    tick();
    clear_inputs();
    dp_if.s1 = 3'b110; dp_if.c0 = 1;
    tick();
    clear_inputs();
    dp_if.c1 = 1; dp_if.en1 = 1;
    repeat (8'h37) tick();
    checks++; if ({dp_if.addr_bus, dp_if.acc, dp_if.opcode} !== {8'h37, 8'hC3, 4'hC}) begin errors++; $display("[TB] FAIL pre_reset: got pc=%h acc=%h op=%h want 37 c3 c", dp_if.addr_bus, dp_if.acc, dp_if.opcode); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({dp_if.addr_bus, dp_if.acc, dp_if.opcode} !== {8'h00, 8'h00, 4'h0}) begin errors++; $display("[TB] FAIL mid_reset: got pc=%h acc=%h op=%h want 00 00 0", dp_if.addr_bus, dp_if.acc, dp_if.opcode); end
    #2;
    rst = 1'b0;
    tick();
    checks++; if (dp_if.addr_bus !== 8'h01) begin errors++; $display("[TB] FAIL post_reset_pc: got %h want 01", dp_if.addr_bus); end
    clear_inputs();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_fetch();
    test_wrap();
    test_alu();
    test_alu_ops();
    test_conflict();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
